// File: rtl/ttt_turn_ctrl_if.sv
// Button and board/status bundle for the tic-tac-toe turn controller.
// The master drives the raw buttons and first-player select; the slave reports game state.
interface ttt_turn_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_place;
  logic       first_o;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic [3:0] cursor;
  logic [6:0] state;
  logic [1:0] winner;
  logic [8:0] win_mask;
  logic [3:0] move_count;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_place, first_o,
    input  board_x, board_o, cursor, state, winner, win_mask, move_count
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_place, first_o,
    output board_x, board_o, cursor, state, winner, win_mask, move_count
  );
endinterface

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn controller: debounces five buttons, moves a cursor,
// places marks for alternating players and detects win or draw.
module ttt_turn_ctrl #(
  parameter int unsigned DEBOUNCE = 4
) (
  input logic           clk,
  input logic           rst,
  ttt_turn_ctrl_if.slave io
);

  localparam int P = 4;
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

  typedef enum logic [6:0] {
    q_Init         = 7'b1000000,
    q_Wait1press   = 7'b0100000,
    q_Wait1release = 7'b0010000,
    q_Wait2press   = 7'b0001000,
    q_Wait2release = 7'b0000100,
    q_Win          = 7'b0000010,
    q_Draw         = 7'b0000001
  } state_t;

  localparam logic [8:0] LINES [8] = '{
    9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054
  };

  state_t     state_q;
  logic [8:0] board_x, board_o, win_mask;
  logic [3:0] cursor, move_count;
  logic [1:0] winner;

  logic [4:0] raw, deb, deb_q, blk, busy, ev;
  logic [7:0] cnt [5];
  logic [8:0] cur_line;
  logic       turn_x;

  function automatic logic [8:0] line_mask(input logic [8:0] b);
    logic [8:0] m;
    m = '0;
    for (int k = 0; k < 8; k++)
      if ((b & LINES[k]) == LINES[k]) m = m | LINES[k];
    return m;
  endfunction

  // dir = {up, down, left, right}; highest set bit wins, wrapping within row/column
  function automatic logic [3:0] step(input logic [3:0] c, input logic [3:0] dir);
    logic [3:0] row, col, r;
    row = c / 4'd3;
    col = c - row * 4'd3;
    if (dir[3])      r = (row == 4'd0) ? c + 4'd6 : c - 4'd3;
    else if (dir[2]) r = (row == 4'd2) ? c - 4'd6 : c + 4'd3;
    else if (dir[1]) r = (col == 4'd0) ? c + 4'd2 : c - 4'd1;
    else if (dir[0]) r = (col == 4'd2) ? c - 4'd2 : c + 4'd1;
    else             r = c;
    return r;
  endfunction

  assign raw = {io.btn_place, io.btn_up, io.btn_down, io.btn_left, io.btn_right};

  always_comb begin
    busy = '0;
    for (int i = 0; i < 5; i++) busy[i] = |cnt[i];
  end

  // Blocked buttons are presses already in progress when a release phase ended
  assign ev       = deb & ~deb_q & ~blk;
  assign turn_x   = (state_q == q_Wait1press);
  assign cur_line = line_mask((state_q == q_Wait1release) ? board_x : board_o);

  always_ff @(posedge clk) begin
    if (!rst) begin
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 5; i++) begin
        if (raw[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= q_Init;
      board_x    <= '0;
      board_o    <= '0;
      cursor     <= 4'd4;
      winner     <= 2'b00;
      win_mask   <= '0;
      move_count <= '0;
      blk        <= '0;
    end else begin
      blk <= blk & (deb | busy);
      case (state_q)
        q_Init: begin
          board_x    <= '0;
          board_o    <= '0;
          cursor     <= 4'd4;
          winner     <= 2'b00;
          win_mask   <= '0;
          move_count <= '0;
          if (deb == 5'b0) state_q <= io.first_o ? q_Wait2press : q_Wait1press;
        end
        q_Wait1press, q_Wait2press: begin
          if (ev[P]) begin
            if (!(board_x[cursor] || board_o[cursor])) begin
              if (turn_x) board_x[cursor] <= 1'b1;
              else        board_o[cursor] <= 1'b1;
              move_count <= move_count + 4'd1;
              state_q    <= turn_x ? q_Wait1release : q_Wait2release;
            end
          end else if (|ev[3:0]) begin
            cursor <= step(cursor, ev[3:0]);
          end
        end
        q_Wait1release, q_Wait2release: begin
          if (deb == 5'b0) begin
            blk <= raw;
            if (cur_line != 9'h000) begin
              state_q  <= q_Win;
              win_mask <= cur_line;
              winner   <= (state_q == q_Wait1release) ? 2'b01 : 2'b10;
            end else if (move_count == 4'd9) begin
              state_q <= q_Draw;
            end else begin
              state_q <= (state_q == q_Wait1release) ? q_Wait2press : q_Wait1press;
            end
          end
        end
        q_Win, q_Draw: begin
          if (ev[P]) begin
            state_q    <= q_Init;
            board_x    <= '0;
            board_o    <= '0;
            cursor     <= 4'd4;
            winner     <= 2'b00;
            win_mask   <= '0;
            move_count <= '0;
          end
        end
        default: state_q <= q_Init;
      endcase
    end
  end

  assign io.board_x    = board_x;
  assign io.board_o    = board_o;
  assign io.cursor     = cursor;
  assign io.state      = state_q;
  assign io.winner     = winner;
  assign io.win_mask   = win_mask;
  assign io.move_count = move_count;

endmodule

// File: doc/ttt_turn_ctrl.md
TTT_TURN_CTRL -- requirements
Module: ttt_turn_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive clk samples a raw button must differ from its debounced level before that level changes; legal range 1..255.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 btn_up, btn_down, btn_left, btn_right, btn_place  in  1 each  raw button levels, 1 = pressed, already synchronised to clk.
REQ-005 first_o  in  1  0 = X moves first, 1 = O moves first; sampled only on INIT exit.
REQ-006 board_x, board_o  out  9 each  cell occupancy; bit i = cell i, i = row*3+col, row 0 at the top; never both set for one cell.
REQ-007 cursor  out  4  selected cell 0..8.
REQ-008 state  out  7  one-hot {q_Init, q_Wait1press, q_Wait1release, q_Wait2press, q_Wait2release, q_Win, q_Draw}, MSB first; exactly one bit set.
REQ-009 winner  out  2  00 none, 01 X, 10 O; 11 never driven.
REQ-010 win_mask  out  9  cells of the completed line in WIN, else 0.
REQ-011 move_count  out  4  placements this game, 0..9.

Function
REQ-012 Per-button debouncer: 8-bit counter clears when raw equals debounced; else increments; debounced toggles and counter clears on the cycle the count reaches DEBOUNCE-1 with raw still differing.
REQ-013 Press event = debounced 0->1, detected against a registered copy; board/cursor/state update on the clk edge after debounced rises.
REQ-014 At most one event acts per cycle; priority place > up > down > left > right; lower-priority simultaneous edges are discarded.
REQ-015 INIT: board, winner, win_mask, move_count cleared, cursor = 4; leaves when all debounced buttons are 0, to Wait1press if first_o = 0, else Wait2press.
REQ-016 Wait1press = X to move, Wait2press = O to move.
REQ-017 In WaitNpress, a direction event moves cursor one cell with wrap in its row/column (up from row 0 -> row 2, right from col 2 -> col 0); state unchanged.
REQ-018 In WaitNpress, place on empty cursor cell sets that cell for player N, increments move_count, goes to WaitNrelease.
REQ-019 Place on an occupied cell is ignored: no board, count or state change.
REQ-020 WaitNrelease ignores all events; when all debounced buttons are 0, evaluates the registered board for 8 lines (3 rows, 3 columns, 2 diagonals): a line of player N -> WIN; else move_count = 9 -> DRAW; else other player's WaitMpress.
REQ-021 Win outranks draw when the ninth placement completes a line.
REQ-022 On WIN entry, winner and win_mask latch; on two simultaneous lines win_mask is the OR of both.
REQ-023 WIN and DRAW: board, cursor and count frozen; place event -> INIT; direction events ignored.
REQ-024 Debouncers run in every state; presses begun during WaitNrelease generate no event after the transition.

Reset
REQ-025 rst = 0 at a rising edge: state = q_Init, board_x = board_o = 0, cursor = 4, winner = 0, win_mask = 0, move_count = 0, all debounced levels, counters and edge registers 0; takes effect the same edge regardless of state, including mid-debounce.
REQ-026 All outputs are register-driven; no combinational path from inputs to outputs.

Verification (DEBOUNCE = 2)
REQ-027 Reset, all buttons low, first_o = 0 -> one cycle after release of rst, state = Wait1press, cursor = 4, board 0.
REQ-028 btn_place high 1 cycle only (glitch) -> no change; held 3 cycles -> board_x = 9'h010, move_count = 1, state = Wait1release; release -> Wait2press.
REQ-029 From cursor 0, up then left (each pressed and released) -> cursor 6 then 8; btn_place and btn_right rising same cycle at cursor 8 -> only cell 8 marked, cursor stays 8.
REQ-030 O places on occupied cell 4 -> board_o unchanged, state stays Wait2press, move_count unchanged.
REQ-031 X marks cells 0,1,2 alternating with O on 3,4 -> after final release state = q_Win, winner = 01, win_mask = 9'h007; place -> INIT -> board 0.
REQ-032 Sequence filling all 9 cells with no line -> state = q_Draw, move_count = 9, winner = 00; ninth move completing a line -> q_Win; rst = 0 in any state -> reset values next edge.
